regfile_param: RTL and testbench
================================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset, named clk and reset.
REQ-002 SHALL have parameter DATA_W, default 16, register width in bits.
REQ-003 SHALL have parameter NUM_REGS, default 16, number of registers (2..256).
REQ-004 SHALL have parameter ADDR_W, default 4, address width; must satisfy 2^ADDR_W >= NUM_REGS.
REQ-005 SHALL have parameter INPUT_REG, default NUM_REGS-1, index of the externally loaded register.
REQ-006 SHALL have port clk  input  1  rising-edge clock.
REQ-007 SHALL have port reset  input  1  synchronous active-high reset.
REQ-008 SHALL have port wr_en  input  1  write strobe.
REQ-009 SHALL have port wr_addr  input  ADDR_W  write address.
REQ-010 SHALL have port wr_data  input  DATA_W  write data.
REQ-011 SHALL have port rd_addr_a  input  ADDR_W  read address, port A.
REQ-012 SHALL have port rd_data_a  output  DATA_W  read data, port A.
REQ-013 SHALL have port rd_addr_b  input  ADDR_W  read address, port B.
REQ-014 SHALL have port rd_data_b  output  DATA_W  read data, port B.
REQ-015 SHALL have port ext_data  input  DATA_W  external (game) input word.
REQ-016 SHALL have port ext_valid  input  1  ext_data valid.
REQ-017 SHALL have port ext_ready  output  1  INPUT_REG accepts ext_data.
REQ-018 SHALL have port clr_start  input  1  request to clear all registers.
REQ-019 SHALL have port busy  output  1  clear sequence in progress.
REQ-020 SHALL have port clr_done  output  1  one-cycle pulse when the clear sequence completes.

Function
REQ-021 SHALL make read ports combinational: rd_data_x = reg[rd_addr_x]; an address >= NUM_REGS returns 0.
REQ-022 SHALL write wr_data to reg[wr_addr] on a clk edge when wr_en=1, busy=0, wr_addr<NUM_REGS, and wr_addr!=INPUT_REG; all other writes are dropped without side effect.
REQ-023 SHALL drive ext_ready = !busy && !reset; load INPUT_REG with ext_data on an edge where ext_valid && ext_ready, otherwise hold it.
REQ-024 SHALL implement FSM states IDLE and CLEAR: IDLE->CLEAR on clr_start=1; CLEAR->IDLE after the edge that clears index NUM_REGS-1.
REQ-025 SHALL, in CLEAR, zero one register per cycle in ascending index order from 0 (INPUT_REG included), taking exactly NUM_REGS cycles; busy=1 throughout CLEAR.
REQ-026 SHALL assert clr_done for exactly one cycle, the first cycle after returning to IDLE.
REQ-027 SHALL ignore clr_start while busy=1; clr_start asserted in the clr_done cycle starts a new sequence.
REQ-028 SHALL keep reads valid during CLEAR, returning current contents (zero for indices already cleared).
REQ-029 SHALL ignore writes with simultaneous wr_en and clr_start in IDLE; the clear wins.

Reset
REQ-030 SHALL, on reset=1 at a clk edge, zero all registers, enter IDLE, and clear the index counter; busy=0, clr_done=0, ext_ready=0 while reset=1.
REQ-031 SHALL abort an in-progress CLEAR on reset, with no clr_done pulse.

Configuration
REQ-032 SHALL use macro REGFILE_BYPASS_EN; when defined, a read port whose address equals a write that is accepted this cycle returns wr_data combinationally, and a read of INPUT_REG returns ext_data when ext_valid&&ext_ready.
REQ-033 SHALL, without REGFILE_BYPASS_EN, return the pre-edge register contents in all cases.

Verification
REQ-034 SHALL cover: reset, then write 0xBEEF to r3 -> rd_data_a(addr 3)=0xBEEF next cycle; write to r15 (INPUT_REG) with 0x1234 -> r15 unchanged.
REQ-035 SHALL cover: ext_valid=1, ext_data=0x00A5 -> r15=0x00A5 after the edge; ext_valid=0 -> r15 holds.
REQ-036 SHALL cover: all regs=0xFFFF, pulse clr_start -> busy high 16 cycles, r0..r15 zero in order, clr_done on cycle 17; wr_en to r2 during busy dropped.
REQ-037 SHALL cover: reset asserted at CLEAR cycle 5 -> all regs 0, busy=0, no clr_done.
REQ-038 SHALL cover: with REGFILE_BYPASS_EN, wr_en r7=0x5A5A and rd_addr_b=7 same cycle -> rd_data_b=0x5A5A that cycle; without it -> old value.
REQ-039 SHALL cover: NUM_REGS=12, ADDR_W=4 -> write to addr 13 dropped, read of addr 13 returns 0, clear takes 12 cycles.

Source files
------------

// File: rtl/regfile_param.sv
// Parameterised register file with two combinational read ports, an externally loaded input register
// and a sequential clear engine. Optional write/ext bypass on reads is enabled by REGFILE_BYPASS_EN.
module regfile_param #(
    parameter int DATA_W    = 16,
    parameter int NUM_REGS  = 16,
    parameter int ADDR_W    = 4,
    parameter int INPUT_REG = NUM_REGS - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic [DATA_W-1:0] ext_data,
    input  logic              ext_valid,
    output logic              ext_ready,
    input  logic              clr_start,
    output logic              busy,
    output logic              clr_done
);
    // Storage is padded to the full address space; unused slots read as zero.
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_idx;
    logic              r_clr_done;

    logic              w_in_clear;
    logic              w_last;
    logic              w_wr_ok;
    logic              w_ext_ok;
    logic [DATA_W-1:0] w_regs [DEPTH];

    assign w_in_clear = (r_state == ST_CLEAR);
    assign w_last     = (r_idx == ADDR_W'(NUM_REGS - 1));

    // A clear request in the same cycle takes precedence over a write.
    assign w_wr_ok  = wr_en && !reset && !w_in_clear && !clr_start
                      && (int'(wr_addr) < NUM_REGS) && (int'(wr_addr) != INPUT_REG);
    assign w_ext_ok = ext_valid && ext_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_clr_done <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_clr_done <= w_in_clear && w_last;
            if (w_in_clear && !w_last) begin
                r_idx <= r_idx + ADDR_W'(1);
            end else begin
                r_idx <= '0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (clr_start) w_state_next = ST_CLEAR;
            ST_CLEAR: if (w_last)    w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = w_in_clear && !reset;
        ext_ready = !w_in_clear && !reset;
        clr_done  = r_clr_done && !reset;
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (gi < NUM_REGS) begin : g_live
                logic [DATA_W-1:0] r_q;
                logic              w_clr_hit;
                logic              w_wr_hit;

                assign w_clr_hit = w_in_clear && (r_idx == ADDR_W'(gi));
                assign w_wr_hit  = w_wr_ok && (wr_addr == ADDR_W'(gi));

                // The input register is fed only from ext_data; the write port never reaches it.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_q <= '0;
                    end else if (w_clr_hit) begin
                        r_q <= '0;
                    end else if (gi == INPUT_REG) begin
                        if (w_ext_ok) r_q <= ext_data;
                    end else if (w_wr_hit) begin
                        r_q <= wr_data;
                    end
                end

                assign w_regs[gi] = r_q;
            end else begin : g_pad
                assign w_regs[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        rd_data_a = w_regs[rd_addr_a];
        rd_data_b = w_regs[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_ok && (rd_addr_a == wr_addr))                rd_data_a = wr_data;
        if (w_wr_ok && (rd_addr_b == wr_addr))                rd_data_b = wr_data;
        if (w_ext_ok && (int'(rd_addr_a) == INPUT_REG))       rd_data_a = ext_data;
        if (w_ext_ok && (int'(rd_addr_b) == INPUT_REG))       rd_data_b = ext_data;
`endif
    end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: vector table, directed clear/reset/bypass sequences,
// a NUM_REGS=12 instance, and randomized traffic against a behavioural model.
module tb_regfile_param;
    localparam int N  = 16;
    localparam int IR = 15;

    logic        clk = 1'b0;
    logic        reset, wr_en, ext_valid, clr_start;
    logic [3:0]  wr_addr, rd_addr_a, rd_addr_b;
    logic [15:0] wr_data, ext_data, rd_data_a, rd_data_b;
    logic        ext_ready, busy, clr_done;

    logic        s_reset, s_wr_en, s_ext_valid, s_clr_start;
    logic [3:0]  s_wr_addr, s_rd_addr_a, s_rd_addr_b;
    logic [15:0] s_wr_data, s_ext_data, s_rd_data_a, s_rd_data_b;
    logic        s_ext_ready, s_busy, s_clr_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_param dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
        .ext_data(ext_data), .ext_valid(ext_valid), .ext_ready(ext_ready),
        .clr_start(clr_start), .busy(busy), .clr_done(clr_done)
    );

    regfile_param #(.DATA_W(16), .NUM_REGS(12), .ADDR_W(4)) dut12 (
        .clk(clk), .reset(s_reset), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .rd_addr_a(s_rd_addr_a), .rd_data_a(s_rd_data_a), .rd_addr_b(s_rd_addr_b), .rd_data_b(s_rd_data_b),
        .ext_data(s_ext_data), .ext_valid(s_ext_valid), .ext_ready(s_ext_ready),
        .clr_start(s_clr_start), .busy(s_busy), .clr_done(s_clr_done)
    );

    // Behavioural model: register contents plus "clear in progress at index m_ci".
    logic [15:0] m_regs [N];
    bit          m_clr;
    int          m_ci;
    bit          m_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            for (int i = 0; i < N; i++) m_regs[i] = '0;
            m_clr = 0; m_ci = 0; m_done = 0;
        end else if (m_clr) begin
            m_regs[m_ci] = '0;
            m_done = (m_ci == N - 1);
            if (m_ci == N - 1) m_clr = 0;
            else m_ci++;
        end else begin
            m_done = 0;
            if (ext_valid) m_regs[IR] = ext_data;
            if (clr_start) begin
                m_clr = 1; m_ci = 0;
            end else if (wr_en && wr_addr != 4'(IR)) begin
                m_regs[wr_addr] = wr_data;
            end
        end
    endtask

    function automatic logic [15:0] model_read(input logic [3:0] a);
        logic [15:0] v;
        v = m_regs[a];
`ifdef REGFILE_BYPASS_EN
        if (!m_clr && !reset) begin
            if (wr_en && !clr_start && wr_addr != 4'(IR) && a == wr_addr) v = wr_data;
            if (ext_valid && a == 4'(IR)) v = ext_data;
        end
`endif
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_addr = 0; wr_data = 0; ext_valid = 0; ext_data = 0; clr_start = 0;
    endtask

    task automatic s_tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        bit        wr_en;
        bit [3:0]  wr_addr;
        bit [15:0] wr_data;
        bit        ext_valid;
        bit [15:0] ext_data;
        bit [3:0]  rd_a;
        bit [15:0] exp_a;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int busy_cnt;
        int guard;

        vecs[0] = '{1'b1, 4'd3,  16'hBEEF, 1'b0, 16'h0000, 4'd3,  16'hBEEF};
        vecs[1] = '{1'b1, 4'd15, 16'h1234, 1'b0, 16'h0000, 4'd15, 16'h0000};
        vecs[2] = '{1'b0, 4'd0,  16'h0000, 1'b1, 16'h00A5, 4'd15, 16'h00A5};
        vecs[3] = '{1'b0, 4'd0,  16'h0000, 1'b0, 16'hFFFF, 4'd15, 16'h00A5};
        vecs[4] = '{1'b1, 4'd0,  16'h0001, 1'b1, 16'h0042, 4'd0,  16'h0001};
        vecs[5] = '{1'b0, 4'd0,  16'h0000, 1'b0, 16'h0000, 4'd15, 16'h0042};
        vecs[6] = '{1'b1, 4'd3,  16'h0002, 1'b0, 16'h0000, 4'd3,  16'h0002};
        vecs[7] = '{1'b1, 4'd3,  16'h0003, 1'b0, 16'h0000, 4'd3,  16'h0003};

        for (int i = 0; i < N; i++) m_regs[i] = '0;
        m_clr = 0; m_ci = 0; m_done = 0;
        idle_inputs();
        rd_addr_a = 0; rd_addr_b = 0; reset = 1;
        s_reset = 1; s_wr_en = 0; s_wr_addr = 0; s_wr_data = 0; s_ext_valid = 0; s_ext_data = 0;
        s_clr_start = 0; s_rd_addr_a = 0; s_rd_addr_b = 0;

        // Reset state
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", clr_done, 0);
        chk("rst_ext_ready", ext_ready, 0);
        chk("rst_rd_a", rd_data_a, 0);
        reset = 0; s_reset = 0;
        #1 chk("ext_ready_idle", ext_ready, 1);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
            ext_valid = vecs[i].ext_valid; ext_data = vecs[i].ext_data; rd_addr_a = vecs[i].rd_a;
            tick();
            idle_inputs();
            #1 chk($sformatf("vec%0d_rd", i), rd_data_a, vecs[i].exp_a);
        end

        // Same-cycle read of a register being written
        wr_en = 1; wr_addr = 7; wr_data = 16'h1111; tick(); idle_inputs();
        wr_en = 1; wr_addr = 7; wr_data = 16'h5A5A; rd_addr_b = 7;
`ifdef REGFILE_BYPASS_EN
        #1 chk("bypass_same_cycle", rd_data_b, 16'h5A5A);
`else
        #1 chk("nobypass_same_cycle", rd_data_b, 16'h1111);
`endif
        tick(); idle_inputs();
        #1 chk("r7_after_edge", rd_data_b, 16'h5A5A);

        // Full clear: fill with FFFF, then check the ascending sweep
        for (int a = 0; a < N - 1; a++) begin
            wr_en = 1; wr_addr = 4'(a); wr_data = 16'hFFFF; tick();
        end
        idle_inputs(); ext_valid = 1; ext_data = 16'hFFFF; tick(); idle_inputs();
        clr_start = 1; tick(); clr_start = 0;
        busy_cnt = busy ? 1 : 0;
        #1 chk("clr_busy_c1", busy, 1);
        for (int k = 0; k < N; k++) begin
            rd_addr_a = 4'(k); rd_addr_b = 4'((k + 1) % N);
            if (k == 0) begin wr_en = 1; wr_addr = 2; wr_data = 16'h1234; end
            tick(); idle_inputs();
            #1;
            chk($sformatf("clr_r%0d_zero", k), rd_data_a, 0);
            if (k < N - 1) chk($sformatf("clr_r%0d_kept", k + 1), rd_data_b, 16'hFFFF);
            if (busy) busy_cnt++;
            if (k == N - 1) chk("clr_done_c17", clr_done, 1);
            else if (k % 5 == 0) chk($sformatf("clr_done_low_%0d", k), clr_done, 0);
        end
        chk("clr_busy_cycles", busy_cnt, 16);
        tick();
        chk("clr_done_one_cycle", clr_done, 0);

        // Reset in the middle of a clear
        wr_en = 1; wr_addr = 10; wr_data = 16'hAAAA; tick(); idle_inputs();
        ext_valid = 1; ext_data = 16'h5555; tick(); idle_inputs();
        clr_start = 1; tick(); clr_start = 0;
        for (int k = 0; k < 4; k++) tick();
        reset = 1;
        #1 chk("abort_busy_in_reset", busy, 0);
        chk("abort_ready_in_reset", ext_ready, 0);
        tick(); reset = 0;
        for (int a = 0; a < N; a++) begin
            rd_addr_a = 4'(a);
            #1 if (a == 10 || a == IR) chk($sformatf("abort_r%0d", a), rd_data_a, 0);
        end
        chk("abort_busy", busy, 0);
        guard = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (clr_done) guard++;
        end
        chk("abort_no_done", guard, 0);

        // NUM_REGS=12 instance
        s_wr_en = 1; s_wr_addr = 13; s_wr_data = 16'h7777; s_tick(); s_wr_en = 0;
        s_rd_addr_a = 13; #1 chk("n12_rd13", s_rd_data_a, 0);
        s_wr_en = 1; s_wr_addr = 11; s_wr_data = 16'h3333; s_tick(); s_wr_en = 0;
        s_rd_addr_a = 11; #1 chk("n12_rd11_input_reg", s_rd_data_a, 0);
        s_wr_en = 1; s_wr_addr = 10; s_wr_data = 16'h4444; s_tick(); s_wr_en = 0;
        s_rd_addr_a = 10; #1 chk("n12_rd10", s_rd_data_a, 16'h4444);
        s_clr_start = 1; s_tick(); s_clr_start = 0;
        busy_cnt = 0; guard = 0;
        while (s_busy && guard < 40) begin
            busy_cnt++; guard++;
            s_tick();
        end
        chk("n12_clear_cycles", busy_cnt, 12);
        chk("n12_clr_done", s_clr_done, 1);
        #1 chk("n12_rd10_cleared", s_rd_data_a, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(63, 0) == 0);
            clr_start = ($urandom_range(23, 0) == 0);
            wr_en     = $urandom_range(1, 0) == 1;
            wr_addr   = 4'($urandom_range(15, 0));
            wr_data   = 16'($urandom);
            ext_valid = ($urandom_range(3, 0) == 0);
            ext_data  = 16'($urandom);
            rd_addr_a = 4'($urandom_range(15, 0));
            rd_addr_b = 4'($urandom_range(15, 0));
            #1;
            chk($sformatf("rnd%0d_rda", n), rd_data_a, model_read(rd_addr_a));
            chk($sformatf("rnd%0d_rdb", n), rd_data_b, model_read(rd_addr_b));
            chk($sformatf("rnd%0d_busy", n), busy, m_clr && !reset);
            chk($sformatf("rnd%0d_done", n), clr_done, m_done && !reset);
            chk($sformatf("rnd%0d_ready", n), ext_ready, !m_clr && !reset);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
